// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with a small {pc, inst} queue feeding decode
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd100
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     dvalid,
    output logic [31:0]              dinst,
    output logic [31:0]              dpc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign imem_addr = pc;
    assign dvalid    = (count != '0);
    assign pop       = dvalid & ~stall & ~redirect;
    // A full queue still accepts a new fetch when the head leaves in the same cycle.
    assign push      = ~redirect & ((count < FULL) | pop);

    assign dinst = dvalid ? q_inst[rptr] : 32'h0;
    assign dpc   = dvalid ? q_pc[rptr]   : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (redirect) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                pc   <= pc + 32'd4;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible through dvalid gating.
    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[wptr]   <= pc;
            q_inst[wptr] <= imem_data;
        end
    end
endmodule
